st_dma: RTL and testbench
=========================

# st_dma

Floppy/hard-disk DMA controller for the STE model. It buffers bytes from or to a byte-wide device port in a 16-byte FIFO and moves them to or from memory in 8-word bursts using the MCU RDY handshake (RDY_O request, RDY_I transfer strobe). It also exposes a CPU-visible mode/status and sector-count register pair through FCS_N/A1. It is the memory-side responder that the MCU's RDY_N_I/RDY_N_O and FCS_N pins talk to.

## Interface
- No parameters. FIFO depth is 16 bytes and the burst length is 8 words, both fixed.
- clk32  in  1  system clock; all state is on posedge.
- resb  in  1  asynchronous active-low reset.
- clk_en  in  1  8 MHz enable (MHZ8_EN1). State changes only when clk_en=1.
- FCS_N  in  1  DMA chip select from MCU, active low.
- RW  in  1  1 = CPU/MCU read, 0 = write.
- A1  in  1  register select: 0 = sector count/data, 1 = mode/status.
- DIN  in  16  data from CPU/memory bus.
- DOUT  out  16  data to bus; FIFO head word during a transfer, otherwise register readback.
- RDY_I  in  1  active-low transfer strobe from MCU (RDY_N_O).
- RDY_O  out  1  active-low burst request to MCU (RDY_N_I).
- DEV_DRQ  in  1  device requests a byte transfer, active high.
- DEV_DIN  in  8  byte from device.
- DEV_DOUT  out  8  byte to device.
- DEV_ACK_N  out  1  byte-accepted/byte-valid strobe, active low, one clk_en period.

## Operation
- Mode register (A1=1 write), 9 bits; only these bits are used:
  - bit8 DIR: 0 = device→memory, 1 = memory→device.
  - bit4 SCSEL.
  - A write whose DIR differs from the current DIR empties the FIFO, clears the byte counter and burst counter, and releases RDY_O.
- CPU register cycle: FCS_N=0 and RDY_I=1, sampled on clk_en. Exactly one write per FCS_N low period (edge-qualified).
- A1=0 write with SCSEL=1: SECCNT ← DIN[7:0], and the 9-bit byte counter is cleared. A1=0 write with SCSEL=0 is ignored.
- Reads:
  - A1=1 returns status {13'b0, DEV_DRQ, SECCNT≠0, 1'b1}.
  - A1=0 returns {8'b0, SECCNT}.
- Device→memory (DIR=0):
  - When DEV_DRQ=1, SECCNT≠0, FIFO<16 and no ACK is pending: push DEV_DIN and drive DEV_ACK_N low for one clk_en period.
  - The device must drop DEV_DRQ before it can be serviced again; a re-arm requires DEV_DRQ seen low.
- Memory→device (DIR=1):
  - When DEV_DRQ=1 and the FIFO is non-empty: DEV_DOUT ← head byte, pop it, and pulse DEV_ACK_N.
  - DEV_DOUT holds its value until the next pop.
- Byte counter: every device byte increments it. At 511→0 (wrap), SECCNT decrements, saturating at 0.
- Byte order is big-endian. Word = {byte n at D15:8, byte n+1 at D7:0}. A pop takes 2 bytes; a push writes 2 bytes.
- Burst request:
  - DIR=0: RDY_O←0 when FIFO=16.
  - DIR=1: RDY_O←0 when FIFO=0 and SECCNT≠0.
  - RDY_O stays 0 until 8 word strobes have completed, then returns to 1 on the same clk_en edge as the 8th strobe.
- Word strobe: RDY_I=0 and FCS_N=0 on clk_en, only counted while RDY_O=0.
  - DIR=0: DOUT = head word, popped on the strobe.
  - DIR=1: DIN pushed on the strobe.
  - Strobes while RDY_O=1 are ignored: no FIFO change, and DOUT shows register readback.
- Simultaneous device push and word pop on the same edge: occupancy changes by +1−2 = −1. No loss, no overflow.
- A device push is never allowed to exceed 16 bytes; a device pop is never allowed on an empty FIFO.

## Timing
- Reset values: DOUT=0, RDY_O=1, DEV_ACK_N=1, DEV_DOUT=0, DIR=0, SCSEL=0, SECCNT=0, FIFO empty, all counters 0. Reset mid-burst aborts immediately.
- DOUT is combinational from the FIFO head or registers; it is valid in the same clk32 cycle that RDY_I/FCS_N/A1 change.
- RDY_O asserts on the first clk_en edge on which its condition holds, i.e. 1 clk_en after the 16th push.
- DEV_ACK_N falls on the clk_en edge that accepts DRQ and rises on the next clk_en edge. Minimum device byte period is 2 clk_en.
- A register write takes effect on the sampling clk_en edge and is visible to a read on the next cycle.

## Test plan
- Reset → DMA: assert resb low mid-burst → RDY_O=1, DEV_ACK_N=1, status reads 0x0001, FIFO empty.
- Device→memory burst: write mode 0x0010, write SECCNT=1, mode 0x0000, feed bytes 0x00..0x0F → RDY_O=0 after 16th ACK; 8 strobes read 0x0001,0x0203,…,0x0E0F; RDY_O=1 with the 8th.
- Sector rollover: DIR=0, SECCNT=2, feed 512 bytes with bursts serviced → SECCNT=1, status bit1=1; after 1024 bytes SECCNT=0 and further DRQ gets no ACK.
- Memory→device: DIR=1, SECCNT=1 → RDY_O=0 at once; write 0xA1B2…×8 → DEV_DOUT sequence A1,B2,…; RDY_O reasserts when FIFO empty again.
- Concurrency: during a DIR=0 burst, DEV_DRQ continuously high → no byte lost or duplicated across 64 bytes, occupancy never >16.
- Direction flush: 5 bytes buffered, write mode with DIR toggled → FIFO empty, RDY_O=1, next burst data starts fresh.

Source files
------------

// File: rtl/st_dma.sv
// st_dma: STE floppy/hard-disk DMA controller. A 16-byte FIFO sits between a
// byte-wide device port and 8-word memory bursts paced by the MCU RDY handshake.
// CPU-visible mode/status and sector-count registers are selected by FCS_N/A1.
module st_dma (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        RDY_I,
  output logic        RDY_O,
  input  logic        DEV_DRQ,
  input  logic [7:0]  DEV_DIN,
  output logic [7:0]  DEV_DOUT,
  output logic        DEV_ACK_N
);
  typedef enum logic {BS_IDLE, BS_BURST} burst_t;

  burst_t     state, state_nx;
  logic       dir, scsel;
  logic [7:0] seccnt;
  logic [8:0] bytecnt;
  logic [2:0] burst_cnt;
  logic [7:0] fifo [16];
  logic [3:0] rd_ptr, wr_ptr, rd_ptr1, wr_ptr1;
  logic [4:0] count, count_nx;
  logic       ack_n, armed, wr_done;
  logic [7:0] dev_dout;
  logic       reg_wr, mode_wr, flush, sec_wr, strobe;
  logic       dev_go, dev_push, dev_pop, word_push, word_pop, req;

  // Decode register writes, word strobes and device service for this clk_en edge
  always_comb begin
    rd_ptr1   = rd_ptr + 4'd1;
    wr_ptr1   = wr_ptr + 4'd1;
    reg_wr    = clk_en & ~FCS_N & RDY_I & ~RW & ~wr_done;
    mode_wr   = reg_wr & A1;
    flush     = mode_wr & (DIN[8] != dir);
    sec_wr    = reg_wr & ~A1 & scsel;
    strobe    = clk_en & ~FCS_N & ~RDY_I & (state == BS_BURST);
    word_pop  = strobe & ~dir & (count >= 5'd2);
    word_push = strobe & dir & (count <= 5'd14);
    dev_go    = clk_en & ~flush & DEV_DRQ & armed & ack_n &
                (dir ? (count != 5'd0) : ((seccnt != 8'd0) & (count != 5'd16)));
    dev_push  = dev_go & ~dir;
    dev_pop   = dev_go & dir;
    count_nx  = count + (dev_push ? 5'd1 : 5'd0) + (word_push ? 5'd2 : 5'd0)
                      - (dev_pop ? 5'd1 : 5'd0) - (word_pop ? 5'd2 : 5'd0);
    req       = dir ? ((count == 5'd0) & (seccnt != 8'd0)) : (count == 5'd16);
  end

  // Burst state register
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) state <= BS_IDLE;
    else       state <= state_nx;
  end

  // Burst request: enter on FIFO full/empty, leave with the 8th word strobe
  always_comb begin
    state_nx = state;
    RDY_O    = (state == BS_IDLE);
    case (state)
      BS_IDLE:  if (clk_en & ~flush & req) state_nx = BS_BURST;
      BS_BURST: if (flush | (strobe & (burst_cnt == 3'd7))) state_nx = BS_IDLE;
      default:  state_nx = BS_IDLE;
    endcase
  end

  // Registers, FIFO storage, byte/sector counters and device handshake
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      dir       <= 1'b0;
      scsel     <= 1'b0;
      seccnt    <= '0;
      bytecnt   <= '0;
      burst_cnt <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ack_n     <= 1'b1;
      armed     <= 1'b1;
      wr_done   <= 1'b0;
      dev_dout  <= '0;
      for (int unsigned i = 0; i < 16; i++) fifo[i] <= '0;
    end else if (clk_en) begin
      if (FCS_N)       wr_done <= 1'b0;
      else if (reg_wr) wr_done <= 1'b1;
      ack_n <= ~dev_go;
      if (dev_go)        armed <= 1'b0;
      else if (!DEV_DRQ) armed <= 1'b1;
      if (mode_wr) begin
        dir   <= DIN[8];
        scsel <= DIN[4];
      end
      if (flush) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        bytecnt   <= '0;
        burst_cnt <= '0;
      end else begin
        if (dev_push) begin
          fifo[wr_ptr] <= DEV_DIN;
          wr_ptr       <= wr_ptr1;
        end
        if (word_push) begin
          fifo[wr_ptr]  <= DIN[15:8];
          fifo[wr_ptr1] <= DIN[7:0];
          wr_ptr        <= wr_ptr + 4'd2;
        end
        if (dev_pop) begin
          dev_dout <= fifo[rd_ptr];
          rd_ptr   <= rd_ptr1;
        end
        if (word_pop) rd_ptr <= rd_ptr + 4'd2;
        count <= count_nx;
        if (strobe) burst_cnt <= burst_cnt + 3'd1;
        if (dev_go) begin
          bytecnt <= bytecnt + 9'd1;
          if ((bytecnt == 9'd511) && (seccnt != 8'd0)) seccnt <= seccnt - 8'd1;
        end
        // a sector-count write overrides a same-edge device byte
        if (sec_wr) begin
          seccnt  <= DIN[7:0];
          bytecnt <= '0;
        end
      end
    end
  end

  // Bus readback: FIFO head word during a DIR=0 strobe, registers otherwise
  always_comb begin
    if ((state == BS_BURST) && !FCS_N && !RDY_I && !dir) DOUT = {fifo[rd_ptr], fifo[rd_ptr1]};
    else if (A1) DOUT = {13'd0, DEV_DRQ, (seccnt != 8'd0), 1'b1};
    else         DOUT = {8'd0, seccnt};
  end

  assign DEV_ACK_N = ack_n;
  assign DEV_DOUT  = dev_dout;

endmodule

// File: tb/tb_st_dma.sv
// tb_st_dma: scoreboard bench for st_dma. Device and memory sides are driven
// by independent processes; a monitor checks every burst word and device byte.
module tb_st_dma;
  logic        clk32 = 1'b0, resb = 1'b0, clk_en = 1'b0;
  logic        FCS_N = 1'b1, RW = 1'b1, A1 = 1'b0, RDY_I = 1'b1, DEV_DRQ = 1'b0;
  logic [15:0] DIN = '0;
  logic [7:0]  DEV_DIN = '0;
  logic [15:0] DOUT;
  logic        RDY_O, DEV_ACK_N;
  logic [7:0]  DEV_DOUT;

  int          total = 0, bad = 0;
  logic [15:0] exp_words[$];
  logic [7:0]  exp_bytes[$];
  bit          m_dir = 1'b0, have_hi = 1'b0, prev_ack = 1'b1;
  logic [7:0]  hi;
  int          m_occ = 0, n_acks = 0, ph = 0;

  st_dma dut (
    .clk32(clk32), .resb(resb), .clk_en(clk_en), .FCS_N(FCS_N), .RW(RW), .A1(A1),
    .DIN(DIN), .DOUT(DOUT), .RDY_I(RDY_I), .RDY_O(RDY_O), .DEV_DRQ(DEV_DRQ),
    .DEV_DIN(DEV_DIN), .DEV_DOUT(DEV_DOUT), .DEV_ACK_N(DEV_ACK_N)
  );

  always #5 clk32 = ~clk32;

  // 8 MHz enable: high for one clk32 cycle in four
  always @(posedge clk32) begin
    #1;
    ph = (ph + 1) % 4;
    clk_en = (ph == 0);
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // Monitor: burst words on DIR=0 strobes, device bytes on DIR=1 ACK falls
  always @(negedge clk32) begin
    if (resb && clk_en && !FCS_N && !RDY_I && !RDY_O && !m_dir) begin
      if (exp_words.size() == 0) begin
        total++;
        bad++;
        $display("FAIL burst_word: got 0x%04h want none", DOUT);
      end else check("burst_word", int'(DOUT), int'(exp_words.pop_front()));
    end
    if (resb && prev_ack && !DEV_ACK_N) begin
      n_acks++;
      if (m_dir) begin
        if (exp_bytes.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dev_byte: got 0x%02h want none", DEV_DOUT);
        end else check("dev_byte", int'(DEV_DOUT), int'(exp_bytes.pop_front()));
      end
    end
    prev_ack = DEV_ACK_N;
  end

  // Advance past exactly one clk_en edge; returns 2 ns after that edge
  task automatic ce();
    logic was;
    do begin
      was = clk_en;
      @(posedge clk32);
      #2;
    end while (!was);
  endtask

  task automatic model_clear();
    exp_words.delete();
    exp_bytes.delete();
    have_hi = 1'b0;
    m_occ = 0;
  endtask

  task automatic wreg(input logic a1, input logic [15:0] d);
    A1 = a1; DIN = d; RW = 1'b0; FCS_N = 1'b0; RDY_I = 1'b1;
    ce();
    if (a1) begin
      if (d[8] != m_dir) model_clear();
      m_dir = d[8];
    end
    FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0;
    ce();
  endtask

  task automatic rd(input logic a1, input string nm, input int exp);
    A1 = a1;
    #1;
    check(nm, int'(DOUT), exp);
    A1 = 1'b0;
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (!DEV_ACK_N) begin ok = 1'b1; break; end
      ce();
    end
    if (!ok) fail_now("ack_wait");
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (!RDY_O) begin ok = 1'b1; break; end
      ce();
    end
    if (!ok) fail_now("rdy_wait");
  endtask

  // Reference: bytes accepted by the device side, paired big-endian into words
  task automatic model_push(input logic [7:0] b);
    m_occ++;
    total++;
    if (m_occ > 16) begin
      bad++;
      $display("FAIL fifo_occ: got %0d want <=16", m_occ);
    end
    if (!have_hi) begin hi = b; have_hi = 1'b1; end
    else begin exp_words.push_back({hi, b}); have_hi = 1'b0; end
  endtask

  task automatic dev_send(input int n, input bit seq, input logic [7:0] base, input int gap);
    bit ok;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = seq ? 8'(base + 8'(i)) : 8'($urandom);
      DEV_DIN = b; DEV_DRQ = 1'b1;
      wait_ack(ok);
      if (!ok) begin DEV_DRQ = 1'b0; return; end
      model_push(b);
      DEV_DRQ = 1'b0;
      ce();
      repeat ($urandom_range(0, gap)) ce();
    end
  endtask

  task automatic dev_recv(input int n, input int gap);
    bit ok;
    for (int i = 0; i < n; i++) begin
      DEV_DRQ = 1'b1;
      wait_ack(ok);
      DEV_DRQ = 1'b0;
      if (!ok) return;
      ce();
      repeat ($urandom_range(0, gap)) ce();
    end
  endtask

  task automatic strobe_rd();
    A1 = 1'b0; RW = 1'b1; FCS_N = 1'b0; RDY_I = 1'b0;
    ce();
    FCS_N = 1'b1; RDY_I = 1'b1;
    m_occ -= 2;
  endtask

  task automatic strobe_wr(input logic [15:0] w);
    exp_bytes.push_back(w[15:8]);
    exp_bytes.push_back(w[7:0]);
    DIN = w; RW = 1'b0; FCS_N = 1'b0; RDY_I = 1'b0;
    ce();
    FCS_N = 1'b1; RDY_I = 1'b1; RW = 1'b1;
  endtask

  task automatic mem_read_bursts(input int nb, input int gap);
    bit ok;
    for (int b = 0; b < nb; b++) begin
      wait_rdy(ok);
      if (!ok) return;
      for (int s = 0; s < 8; s++) begin
        strobe_rd();
        if (s == 6) check("rdy_held", int'(RDY_O), 0);
        if (s < 7) repeat ($urandom_range(0, gap)) ce();
      end
      check("rdy_release", int'(RDY_O), 1);
    end
  endtask

  task automatic mem_write_bursts(input int nb, input int gap, input bit fixed_first);
    bit ok;
    logic [15:0] fx [8];
    fx = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718, 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
    for (int b = 0; b < nb; b++) begin
      wait_rdy(ok);
      if (!ok) return;
      for (int s = 0; s < 8; s++) begin
        strobe_wr((fixed_first && b == 0) ? fx[s] : 16'($urandom));
        if (s == 6) check("wr_rdy_held", int'(RDY_O), 0);
        if (s < 7) repeat ($urandom_range(0, gap)) ce();
      end
      check("wr_rdy_release", int'(RDY_O), 1);
    end
  endtask

  initial begin
    int acks0;
    bit ok;

    // reset state
    repeat (3) @(posedge clk32);
    #2;
    check("rst_rdy", int'(RDY_O), 1);
    check("rst_ack", int'(DEV_ACK_N), 1);
    check("rst_devdout", int'(DEV_DOUT), 0);
    check("rst_dout", int'(DOUT), 0);
    rd(1'b1, "rst_status", 16'h0001);
    resb = 1'b1;
    ce();

    // device->memory, one burst with known bytes
    wreg(1'b1, 16'h0010);
    wreg(1'b0, 16'h0001);
    wreg(1'b1, 16'h0000);
    rd(1'b0, "seccnt_1", 16'h0001);
    rd(1'b1, "status_busy", 16'h0003);
    dev_send(15, 1'b1, 8'h00, 0);
    DEV_DIN = 8'h0F; DEV_DRQ = 1'b1;
    wait_ack(ok);
    if (ok) model_push(8'h0F);
    check("rdy_not_early", int'(RDY_O), 1);
    DEV_DRQ = 1'b0;
    ce();
    check("rdy_after_full", int'(RDY_O), 0);
    mem_read_bursts(1, 0);
    check("words_drained_a", exp_words.size(), 0);

    // sector rollover with concurrent device traffic and bursts
    wreg(1'b1, 16'h0010);
    wreg(1'b0, 16'h0002);
    wreg(1'b1, 16'h0000);
    fork
      dev_send(512, 1'b0, 8'h00, 1);
      mem_read_bursts(32, 1);
    join
    rd(1'b0, "seccnt_after512", 16'h0001);
    rd(1'b1, "status_after512", 16'h0003);
    fork
      dev_send(512, 1'b0, 8'h00, 0);
      mem_read_bursts(32, 2);
    join
    rd(1'b0, "seccnt_after1024", 16'h0000);
    rd(1'b1, "status_after1024", 16'h0001);
    acks0 = n_acks;
    DEV_DRQ = 1'b1;
    repeat (20) ce();
    rd(1'b1, "status_drq", 16'h0005);
    check("no_ack_seccnt0", n_acks, acks0);
    DEV_DRQ = 1'b0;
    ce();
    check("words_drained_b", exp_words.size(), 0);

    // memory->device
    wreg(1'b1, 16'h0010);
    wreg(1'b0, 16'h0001);
    wreg(1'b1, 16'h0110);
    check("m2d_rdy_at_once", int'(RDY_O), 0);
    fork
      mem_write_bursts(32, 1, 1'b1);
      dev_recv(512, 1);
    join
    repeat (10) ce();
    check("m2d_rdy_idle_end", int'(RDY_O), 1);
    rd(1'b0, "m2d_seccnt0", 16'h0000);
    check("bytes_drained", exp_bytes.size(), 0);

    // direction flush with partial FIFO
    wreg(1'b1, 16'h0010);
    wreg(1'b0, 16'h0003);
    dev_send(5, 1'b1, 8'h20, 0);
    check("partial_rdy", int'(RDY_O), 1);
    A1 = 1'b0; FCS_N = 1'b0; RDY_I = 1'b0;
    #1;
    check("stray_strobe_dout", int'(DOUT), 16'h0003);
    ce();
    FCS_N = 1'b1; RDY_I = 1'b1;
    wreg(1'b1, 16'h0110);
    wreg(1'b1, 16'h0010);
    check("flush_rdy", int'(RDY_O), 1);
    dev_send(16, 1'b1, 8'h40, 0);
    mem_read_bursts(1, 0);
    check("words_drained_c", exp_words.size(), 0);

    // reset in the middle of a burst
    dev_send(16, 1'b0, 8'h00, 0);
    wait_rdy(ok);
    repeat (3) strobe_rd();
    resb = 1'b0;
    #3;
    check("midrst_rdy", int'(RDY_O), 1);
    check("midrst_ack", int'(DEV_ACK_N), 1);
    check("midrst_devdout", int'(DEV_DOUT), 0);
    rd(1'b1, "midrst_status", 16'h0001);
    rd(1'b0, "midrst_dout", 16'h0000);
    model_clear();
    m_dir = 1'b0;
    repeat (2) ce();
    resb = 1'b1;
    ce();
    wreg(1'b1, 16'h0010);
    wreg(1'b0, 16'h0001);
    wreg(1'b1, 16'h0000);
    dev_send(16, 1'b1, 8'h80, 0);
    mem_read_bursts(1, 0);
    check("words_drained_d", exp_words.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
